// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared types and constants for the RV32I pipeline control logic.
//   hz_state_t : hazard controller FSM state (RUN, MEM_WAIT, FAULT)
//   FWD_*      : Execute operand forwarding selects
//   fwd_sel    : forwarding select for one Execute source operand
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   // Memory stage wins over Writeback because it holds the younger result.
   // x0 is never forwarded since it always reads as zero.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       we_m,
                                          input logic [4:0] rd_w,
                                          input logic       we_w);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (we_m && (rd_m != 5'd0) && (rd_m == rs))
         sel = FWD_MEM;
      else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that stops at all-ones instead of wrapping.
//   i_Clk   : clock, rising edge
//   i_Reset : synchronous active-high clear
//   i_Inc   : count this cycle
//   o_Count : current count (registered)
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_Clk,
   input  logic         i_Reset,
   input  logic         i_Inc,
   output logic [W-1:0] o_Count
);

   always_ff @(posedge i_Clk) begin
      if (i_Reset)
         o_Count <= '0;
      else if (i_Inc && (o_Count != {W{1'b1}}))
         o_Count <= o_Count + 1'b1;
   end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
//   Stall / flush / forwarding control for the five-stage RV32I pipeline.
//   Resolves load-use, taken-branch and multi-cycle data-memory hazards,
//   watches memory waits for a timeout, and counts stall and flush cycles.
//
//   Inputs : i_Clk, i_Reset (sync, active high), Decode sources i_Rs1D/i_Rs2D,
//            Execute i_Rs1E/i_Rs2E/i_RdE/i_ResultSrcE0/i_PCSrcE,
//            Memory i_RdM/i_RegWriteM/i_MemReqM/i_MemReadyM,
//            Writeback i_RdW/i_RegWriteW.
//   Outputs: o_StallF/D/E/M, o_FlushD/E/W, o_ForwardAE/BE (combinational),
//            o_MemFault (sticky), o_StallCount/o_FlushCount (saturating),
//            o_State (current FSM state, for observation).
//
//   Handshake: the Memory stage access completes in the cycle where
//   i_MemReqM && i_MemReadyM; every cycle with i_MemReqM && !i_MemReadyM
//   freezes F/D/E/M and bubbles Writeback.
module hazard_controller
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic [4:0]       i_Rs1D,
   input  logic [4:0]       i_Rs2D,
   input  logic [4:0]       i_Rs1E,
   input  logic [4:0]       i_Rs2E,
   input  logic [4:0]       i_RdE,
   input  logic             i_ResultSrcE0,
   input  logic             i_PCSrcE,
   input  logic [4:0]       i_RdM,
   input  logic [4:0]       i_RdW,
   input  logic             i_RegWriteM,
   input  logic             i_RegWriteW,
   input  logic             i_MemReqM,
   input  logic             i_MemReadyM,
   output logic             o_StallF,
   output logic             o_StallD,
   output logic             o_StallE,
   output logic             o_StallM,
   output logic             o_FlushD,
   output logic             o_FlushE,
   output logic             o_FlushW,
   output logic [1:0]       o_ForwardAE,
   output logic [1:0]       o_ForwardBE,
   output logic             o_MemFault,
   output logic [CNT_W-1:0] o_StallCount,
   output logic [CNT_W-1:0] o_FlushCount,
   output hz_state_t        o_State
);

   // Last wait-count value that may still see a completion; one more
   // not-ready cycle there means the memory has hung.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   hz_state_t  state_q, state_n;
   logic [7:0] wait_q, wait_n;
   logic       mem_stall;
   logic       lw_stall;

   assign mem_stall = (state_q != FAULT) && i_MemReqM && !i_MemReadyM;

   assign lw_stall = i_ResultSrcE0 && (i_RdE != 5'd0) &&
                     ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));

   // State register
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q <= RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_n;
         wait_q  <= wait_n;
      end
   end

   // Next-state and wait counter
   always_comb begin
      state_n = state_q;
      wait_n  = wait_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               if (wait_q == WAIT_LAST) begin
                  state_n = FAULT;
               end else begin
                  state_n = MEM_WAIT;
                  wait_n  = wait_q + 8'd1;
               end
            end else begin
               wait_n = '0;
            end
         end
         MEM_WAIT: begin
            if (mem_stall) begin
               if (wait_q == WAIT_LAST)
                  state_n = FAULT;
               else
                  wait_n = wait_q + 8'd1;
            end else if (i_MemReadyM) begin
               state_n = RUN;
               wait_n  = '0;
            end
         end
         FAULT: begin
            state_n = FAULT;
         end
         default: begin
            state_n = RUN;
            wait_n  = '0;
         end
      endcase
   end

   // Pipeline controls. A memory wait outranks branch and load-use so the
   // branch stays in Execute and redirects once the wait is over.
   always_comb begin
      o_StallF    = 1'b0;
      o_StallD    = 1'b0;
      o_StallE    = 1'b0;
      o_StallM    = 1'b0;
      o_FlushD    = 1'b0;
      o_FlushE    = 1'b0;
      o_FlushW    = 1'b0;
      o_ForwardAE = FWD_NONE;
      o_ForwardBE = FWD_NONE;
      if (i_Reset) begin
         o_FlushD = 1'b1;
         o_FlushE = 1'b1;
         o_FlushW = 1'b1;
      end else if (state_q == FAULT || mem_stall) begin
         o_StallF = 1'b1;
         o_StallD = 1'b1;
         o_StallE = 1'b1;
         o_StallM = 1'b1;
         o_FlushW = 1'b1;
         if (state_q != FAULT) begin
            o_ForwardAE = fwd_sel(i_Rs1E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
            o_ForwardBE = fwd_sel(i_Rs2E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
         end
      end else begin
         if (lw_stall) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_FlushE = 1'b1;
         end
         if (i_PCSrcE) begin
            o_FlushD = 1'b1;
            o_FlushE = 1'b1;
         end
         o_ForwardAE = fwd_sel(i_Rs1E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
         o_ForwardBE = fwd_sel(i_Rs2E, i_RdM, i_RegWriteM, i_RdW, i_RegWriteW);
      end
   end

   assign o_MemFault = (state_q == FAULT) && !i_Reset;
   assign o_State    = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Inc   (o_StallF),
      .o_Count (o_StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Inc   (o_FlushD),
      .o_Count (o_FlushCount)
   );

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed bench for hazard_controller built with MEM_TIMEOUT = 4 and
//   CNT_W = 4 so that timeout and counter saturation are reached quickly.
//   Inputs are driven just after the falling edge; combinational outputs are
//   checked 1ns later and registered outputs 1ns after the rising edge.
module tb_hazard_controller;
   import pipeline_pkg::*;

   localparam int T_OUT = 4;
   localparam int CW    = 4;

   logic          clk;
   logic          rst;
   logic [4:0]    rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic          ressrc, pcsrc, regwm, regww, memreq, memrdy;
   logic          stall_f, stall_d, stall_e, stall_m;
   logic          flush_d, flush_e, flush_w;
   logic [1:0]    fwd_a, fwd_b;
   logic          mem_fault;
   logic [CW-1:0] stall_cnt, flush_cnt;
   hz_state_t     state;

   int total = 0;
   int bad   = 0;

   hazard_controller #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Rs1D        (rs1d),
      .i_Rs2D        (rs2d),
      .i_Rs1E        (rs1e),
      .i_Rs2E        (rs2e),
      .i_RdE         (rde),
      .i_ResultSrcE0 (ressrc),
      .i_PCSrcE      (pcsrc),
      .i_RdM         (rdm),
      .i_RdW         (rdw),
      .i_RegWriteM   (regwm),
      .i_RegWriteW   (regww),
      .i_MemReqM     (memreq),
      .i_MemReadyM   (memrdy),
      .o_StallF      (stall_f),
      .o_StallD      (stall_d),
      .o_StallE      (stall_e),
      .o_StallM      (stall_m),
      .o_FlushD      (flush_d),
      .o_FlushE      (flush_e),
      .o_FlushW      (flush_w),
      .o_ForwardAE   (fwd_a),
      .o_ForwardBE   (fwd_b),
      .o_MemFault    (mem_fault),
      .o_StallCount  (stall_cnt),
      .o_FlushCount  (flush_cnt),
      .o_State       (state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic drive_idle();
      rs1d = 5'd0; rs2d = 5'd0; rs1e = 5'd0; rs2e = 5'd0;
      rde = 5'd0; rdm = 5'd0; rdw = 5'd0;
      ressrc = 1'b0; pcsrc = 1'b0; regwm = 1'b0; regww = 1'b0;
      memreq = 1'b0; memrdy = 1'b0;
   endtask

   task automatic drive_slot();
      @(negedge clk);
   endtask

   task automatic pass_edge();
      @(posedge clk);
      #1;
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      drive_slot(); #1;
      total++;
      if ({flush_d, flush_e, flush_w} !== 3'b111) begin
         bad++; $display("FAIL reset_flush got=%b want=111", {flush_d, flush_e, flush_w});
      end
      total++;
      if ({stall_f, stall_d, stall_e, stall_m} !== 4'b0000) begin
         bad++; $display("FAIL reset_stall got=%b want=0000", {stall_f, stall_d, stall_e, stall_m});
      end
      total++;
      if (mem_fault !== 1'b0) begin
         bad++; $display("FAIL reset_fault got=%b want=0", mem_fault);
      end
      pass_edge();
      total++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
         bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
      end
      total++;
      if (state !== RUN) begin
         bad++; $display("FAIL reset_state got=%0d want=%0d", state, RUN);
      end
      drive_slot();
      rst = 1'b0;
   endtask

   task automatic test_forward();
      drive_idle();
      rdm = 5'd7; rdw = 5'd7; regwm = 1'b1; regww = 1'b1; rs1e = 5'd7; rs2e = 5'd7;
      #1;
      total++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
         bad++; $display("FAIL fwd_mem_prio got=%b/%b want=10/10", fwd_a, fwd_b);
      end
      rdm = 5'd0;
      #1;
      total++;
      if (fwd_a !== 2'b01) begin
         bad++; $display("FAIL fwd_wb got=%b want=01", fwd_a);
      end
      rdm = 5'd7; regwm = 1'b0; rs2e = 5'd3;
      #1;
      total++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
         bad++; $display("FAIL fwd_wen got=%b/%b want=01/00", fwd_a, fwd_b);
      end
      regwm = 1'b1; rdm = 5'd0; rdw = 5'd0; rs1e = 5'd0;
      #1;
      total++;
      if (fwd_a !== 2'b00) begin
         bad++; $display("FAIL fwd_x0 got=%b want=00", fwd_a);
      end
      total++;
      if ({stall_f, flush_d, flush_e, flush_w} !== 4'b0000) begin
         bad++; $display("FAIL fwd_quiet got=%b want=0000", {stall_f, flush_d, flush_e, flush_w});
      end
      drive_idle();
   endtask

   task automatic test_load_use();
      drive_slot();
      ressrc = 1'b1; rde = 5'd0; rs1d = 5'd0;
      #1;
      total++;
      if (stall_f !== 1'b0 || flush_e !== 1'b0) begin
         bad++; $display("FAIL lw_x0 got=%b%b want=00", stall_f, flush_e);
      end
      rde = 5'd5; rs1d = 5'd5;
      #1;
      total++;
      if ({stall_f, stall_d, flush_e, stall_e, stall_m, flush_d} !== 6'b111000) begin
         bad++; $display("FAIL lw_stall got=%b want=111000",
                         {stall_f, stall_d, flush_e, stall_e, stall_m, flush_d});
      end
      pass_edge();
      total++;
      if (stall_cnt !== 4'd1) begin
         bad++; $display("FAIL lw_count got=%0d want=1", stall_cnt);
      end
      drive_slot();
      drive_idle();
      rs2d = 5'd9; rde = 5'd9; ressrc = 1'b1;
      #1;
      total++;
      if (stall_d !== 1'b1) begin
         bad++; $display("FAIL lw_rs2 got=%b want=1", stall_d);
      end
      ressrc = 1'b0;
      #1;
      total++;
      if (stall_d !== 1'b0) begin
         bad++; $display("FAIL lw_notload got=%b want=0", stall_d);
      end
      drive_idle();
   endtask

   task automatic test_branch();
      drive_slot();
      pcsrc = 1'b1;
      #1;
      total++;
      if ({flush_d, flush_e, stall_f, flush_w} !== 4'b1100) begin
         bad++; $display("FAIL br_flush got=%b want=1100", {flush_d, flush_e, stall_f, flush_w});
      end
      pass_edge();
      total++;
      if (flush_cnt !== 4'd1) begin
         bad++; $display("FAIL br_count got=%0d want=1", flush_cnt);
      end
      // branch and load-use together: both sets of controls appear
      drive_slot();
      ressrc = 1'b1; rde = 5'd4; rs2d = 5'd4;
      #1;
      total++;
      if ({stall_f, stall_d, flush_d, flush_e} !== 4'b1111) begin
         bad++; $display("FAIL br_lw_or got=%b want=1111", {stall_f, stall_d, flush_d, flush_e});
      end
      pass_edge();
      total++;
      if (stall_cnt !== 4'd2 || flush_cnt !== 4'd2) begin
         bad++; $display("FAIL br_lw_counts got=%0d/%0d want=2/2", stall_cnt, flush_cnt);
      end
      drive_slot();
      drive_idle();
   endtask

   task automatic test_mem_wait();
      drive_slot();
      memreq = 1'b1; memrdy = 1'b0; pcsrc = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if ({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e} !== 7'b1111100) begin
            bad++; $display("FAIL memwait_cyc%0d got=%b want=1111100", c,
                            {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e});
         end
         pass_edge();
         total++;
         if (mem_fault !== 1'b0) begin
            bad++; $display("FAIL memwait_nofault%0d got=%b want=0", c, mem_fault);
         end
         drive_slot();
      end
      // completion on the last legal wait cycle; held branch redirects now
      memrdy = 1'b1;
      #1;
      total++;
      if ({stall_f, stall_m, flush_w, flush_d, flush_e} !== 5'b00011) begin
         bad++; $display("FAIL memwait_done got=%b want=00011",
                         {stall_f, stall_m, flush_w, flush_d, flush_e});
      end
      pass_edge();
      total++;
      if (mem_fault !== 1'b0 || state !== RUN) begin
         bad++; $display("FAIL memwait_end got=fault%b st%0d want=fault0 st0", mem_fault, state);
      end
      total++;
      if (stall_cnt !== 4'd5 || flush_cnt !== 4'd3) begin
         bad++; $display("FAIL memwait_counts got=%0d/%0d want=5/3", stall_cnt, flush_cnt);
      end
      drive_slot();
      drive_idle();
   endtask

   task automatic test_timeout();
      drive_slot();
      memreq = 1'b1; memrdy = 1'b0;
      for (int e = 1; e <= T_OUT; e++) begin
         pass_edge();
         total++;
         if (mem_fault !== (e == T_OUT)) begin
            bad++; $display("FAIL timeout_edge%0d got=%b want=%b", e, mem_fault, (e == T_OUT));
         end
      end
      drive_slot();
      memrdy = 1'b1; pcsrc = 1'b1;
      rdm = 5'd6; regwm = 1'b1; rs1e = 5'd6;
      #1;
      total++;
      if ({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e} !== 7'b1111100) begin
         bad++; $display("FAIL fault_ctrl got=%b want=1111100",
                         {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e});
      end
      total++;
      if (fwd_a !== FWD_NONE) begin
         bad++; $display("FAIL fault_fwd got=%b want=00", fwd_a);
      end
      pass_edge();
      drive_slot();
      pass_edge();
      total++;
      if (mem_fault !== 1'b1 || state !== FAULT) begin
         bad++; $display("FAIL fault_sticky got=fault%b st%0d want=fault1 st2", mem_fault, state);
      end
      total++;
      if (stall_cnt !== 4'd11 || flush_cnt !== 4'd3) begin
         bad++; $display("FAIL fault_counts got=%0d/%0d want=11/3", stall_cnt, flush_cnt);
      end
      drive_slot();
      rst = 1'b1;
      #1;
      total++;
      if (mem_fault !== 1'b0 || stall_f !== 1'b0 || flush_d !== 1'b1) begin
         bad++; $display("FAIL fault_rst_comb got=%b%b%b want=001", mem_fault, stall_f, flush_d);
      end
      pass_edge();
      total++;
      if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || state !== RUN) begin
         bad++; $display("FAIL fault_rst_clear got=%0d/%0d st%0d want=0/0 st0",
                         stall_cnt, flush_cnt, state);
      end
      drive_slot();
      rst = 1'b0;
      drive_idle();
      #1;
      total++;
      if (mem_fault !== 1'b0 || stall_f !== 1'b0) begin
         bad++; $display("FAIL fault_after_rst got=%b%b want=00", mem_fault, stall_f);
      end
   endtask

   task automatic test_saturation();
      drive_slot();
      ressrc = 1'b1; rde = 5'd12; rs1d = 5'd12;
      for (int n = 1; n <= 20; n++) begin
         pass_edge();
         total++;
         if (stall_cnt !== CW'((n > 15) ? 15 : n)) begin
            bad++; $display("FAIL sat_cycle%0d got=%0d want=%0d", n, stall_cnt, (n > 15) ? 15 : n);
         end
      end
      total++;
      if (flush_cnt !== 4'd0) begin
         bad++; $display("FAIL sat_flush got=%0d want=0", flush_cnt);
      end
      drive_slot();
      drive_idle();
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      test_reset();
      test_forward();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
